// File: rtl/bv_pkg.sv
// ------------------------------------------------------------------
// bv_pkg: shared bit-vector widths and clog2 helper.   Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package bv_pkg;

   localparam int BV_WIDTH_DEF  = 32;
   localparam int SEG_WIDTH_DEF = 8;
   localparam int IDX_WIDTH_DEF = 5;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bv_seg_pe.sv
// ------------------------------------------------------------------
// bv_seg_pe: combinational lowest-set-bit encoder for one segment. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module bv_seg_pe
   import bv_pkg::*;
#(
   parameter int SEG_WIDTH = SEG_WIDTH_DEF,
   parameter int OFF_WIDTH = clog2(SEG_WIDTH)
) (
   input  logic [SEG_WIDTH-1:0] seg,
   output logic                 any_set,
   output logic [OFF_WIDTH-1:0] offset
);

   always_comb begin
      any_set = |seg;
      offset  = '0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = SEG_WIDTH - 1; i >= 0; i--) begin
         if (seg[i]) offset = OFF_WIDTH'(i);
      end
   end

endmodule

`default_nettype wire

// File: rtl/bv_match_encoder.sv
// ------------------------------------------------------------------
// bv_match_encoder: AND field vectors, 3-stage lowest-match encode. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module bv_match_encoder
   import bv_pkg::*;
#(
   parameter int NUM_FIELDS = 4,
   parameter int BV_WIDTH   = BV_WIDTH_DEF,
   parameter int SEG_WIDTH  = SEG_WIDTH_DEF,
   parameter int IDX_WIDTH  = IDX_WIDTH_DEF,
   parameter int TAG_WIDTH  = 8,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           bv_valid_in,
   input  logic [NUM_FIELDS*BV_WIDTH-1:0] bv_in,
   input  logic [TAG_WIDTH-1:0]           tag_in,
   output logic                           match_valid,
   output logic                           match_hit,
   output logic [IDX_WIDTH-1:0]           match_idx,
   output logic [TAG_WIDTH-1:0]           match_tag,
   input  logic                           cnt_clr,
   output logic [CNT_WIDTH-1:0]           hit_cnt,
   output logic [CNT_WIDTH-1:0]           miss_cnt
);

   localparam int NUM_SEGS  = BV_WIDTH / SEG_WIDTH;
   localparam int OFF_WIDTH = clog2(SEG_WIDTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic [BV_WIDTH-1:0]           and_vec;
   logic                          s1_valid;
   logic [BV_WIDTH-1:0]           s1_vec;
   logic [TAG_WIDTH-1:0]          s1_tag;
   logic [NUM_SEGS-1:0]           seg_any;
   logic [NUM_SEGS*OFF_WIDTH-1:0] seg_off;
   logic                          s2_valid;
   logic [NUM_SEGS-1:0]           s2_any;
   logic [NUM_SEGS*OFF_WIDTH-1:0] s2_off;
   logic [TAG_WIDTH-1:0]          s2_tag;
   logic                          sel_hit;
   logic [IDX_WIDTH-1:0]          sel_idx;

   always_comb begin
      and_vec = '1;
      for (int f = 0; f < NUM_FIELDS; f++) begin
         and_vec = and_vec & bv_in[f*BV_WIDTH +: BV_WIDTH];
      end
   end

   generate
      for (genvar s = 0; s < NUM_SEGS; s++) begin : g_seg
         bv_seg_pe #(
            .SEG_WIDTH (SEG_WIDTH),
            .OFF_WIDTH (OFF_WIDTH)
         ) u_pe (
            .seg     (s1_vec[s*SEG_WIDTH +: SEG_WIDTH]),
            .any_set (seg_any[s]),
            .offset  (seg_off[s*OFF_WIDTH +: OFF_WIDTH])
         );
      end
   endgenerate

   // Lowest-numbered segment with a set bit wins; scanning downward lets it overwrite.
   always_comb begin
      sel_hit = 1'b0;
      sel_idx = '0;
      for (int s = NUM_SEGS - 1; s >= 0; s--) begin
         if (s2_any[s]) begin
            sel_hit = 1'b1;
            sel_idx = IDX_WIDTH'(s * SEG_WIDTH) + IDX_WIDTH'(s2_off[s*OFF_WIDTH +: OFF_WIDTH]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s2_valid    <= 1'b0;
         match_valid <= 1'b0;
         match_hit   <= 1'b0;
         match_idx   <= '0;
         match_tag   <= '0;
      end else begin
         s1_valid    <= bv_valid_in;
         s2_valid    <= s1_valid;
         match_valid <= s2_valid;
         if (s2_valid) begin
            match_hit <= sel_hit;
            match_idx <= sel_idx;
            match_tag <= s2_tag;
         end
      end
   end

   // Data stages load only on valid so idle bv_in never reaches the result.
   always_ff @(posedge clk) begin
      if (bv_valid_in) begin
         s1_vec <= and_vec;
         s1_tag <= tag_in;
      end
      if (s1_valid) begin
         s2_any <= seg_any;
         s2_off <= seg_off;
         s2_tag <= s1_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || cnt_clr) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (match_valid) begin
         if (match_hit) begin
            if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_WIDTH'(1);
         end else begin
            if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bv_match_encoder.sv
// ------------------------------------------------------------------
// tb_bv_match_encoder: random + directed checks against a lookup model. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_bv_match_encoder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         bv_valid_in;
   logic [127:0] bv_in;
   logic [7:0]   tag_in;
   logic         cnt_clr;

   logic         match_valid, match_hit;
   logic [4:0]   match_idx;
   logic [7:0]   match_tag;
   logic [31:0]  hit_cnt, miss_cnt;

   logic         mv_s, hit_s;
   logic [4:0]   idx_s;
   logic [7:0]   tag_s;
   logic [2:0]   hc_s, mc_s;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   always #5 clk = ~clk;

   bv_match_encoder dut (
      .clk(clk), .rst_n(rst_n), .bv_valid_in(bv_valid_in), .bv_in(bv_in), .tag_in(tag_in),
      .match_valid(match_valid), .match_hit(match_hit), .match_idx(match_idx),
      .match_tag(match_tag), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   // Narrow-counter instance so saturation is reachable in a short run.
   bv_match_encoder #(.CNT_WIDTH(3)) dut_s (
      .clk(clk), .rst_n(rst_n), .bv_valid_in(bv_valid_in), .bv_in(bv_in), .tag_in(tag_in),
      .match_valid(mv_s), .match_hit(hit_s), .match_idx(idx_s),
      .match_tag(tag_s), .cnt_clr(cnt_clr), .hit_cnt(hc_s), .miss_cnt(mc_s)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void ref_lookup(input logic [127:0] bv, output logic hit,
                                      output logic [4:0] idx);
      logic [31:0] a;
      a = '1;
      for (int f = 0; f < 4; f++) a = a & bv[f*32 +: 32];
      hit = 1'b0;
      idx = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (a[i] && !hit) begin
            hit = 1'b1;
            idx = 5'(i);
         end
      end
   endfunction

   typedef struct {
      int         due;
      logic       hit;
      logic [4:0] idx;
      logic [7:0] tag;
   } pend_t;

   pend_t       pend[$];
   int          edge_no = 0;
   logic        m_mv = 1'b0, m_hit = 1'b0;
   logic [4:0]  m_idx = '0;
   logic [7:0]  m_tag = '0;
   logic [31:0] m_hc = '0, m_mc = '0;
   logic [2:0]  m_hcs = '0, m_mcs = '0;

   // Reference model: each accepted lookup emerges exactly three cycles later.
   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n || cnt_clr) begin
            m_hc = '0; m_mc = '0; m_hcs = '0; m_mcs = '0;
         end else if (m_mv) begin
            if (m_hit) begin
               if (m_hc  != 32'hFFFF_FFFF) m_hc++;
               if (m_hcs != 3'd7)          m_hcs++;
            end else begin
               if (m_mc  != 32'hFFFF_FFFF) m_mc++;
               if (m_mcs != 3'd7)          m_mcs++;
            end
         end
         if (!rst_n) begin
            m_mv = 1'b0; m_hit = 1'b0; m_idx = '0; m_tag = '0;
            pend.delete();
         end else if (pend.size() > 0 && pend[0].due == edge_no) begin
            pend_t e;
            e = pend.pop_front();
            m_mv = 1'b1; m_hit = e.hit; m_idx = e.idx; m_tag = e.tag;
         end else begin
            m_mv = 1'b0;
         end
         if (rst_n && bv_valid_in) begin
            pend_t n;
            ref_lookup(bv_in, n.hit, n.idx);
            n.due = edge_no + 2;
            n.tag = tag_in;
            pend.push_back(n);
         end
         edge_no++;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("match_valid", 64'(match_valid), 64'(m_mv));
            check("match_valid_s", 64'(mv_s), 64'(m_mv));
            if (m_mv) begin
               check("match_hit", 64'(match_hit), 64'(m_hit));
               check("match_idx", 64'(match_idx), 64'(m_idx));
               check("match_tag", 64'(match_tag), 64'(m_tag));
               check("match_idx_s", 64'(idx_s), 64'(m_idx));
            end
            check("hit_cnt", 64'(hit_cnt), 64'(m_hc));
            check("miss_cnt", 64'(miss_cnt), 64'(m_mc));
            check("hit_cnt_s", 64'(hc_s), 64'(m_hcs));
            check("miss_cnt_s", 64'(mc_s), 64'(m_mcs));
         end
      end
   end

   function automatic logic [31:0] rfield();
      case ($urandom_range(0, 4))
         0, 1:    return 32'hFFFF_FFFF;
         2:       return $urandom | $urandom;
         3:       return $urandom;
         default: return $urandom & 32'hFF00_0000;
      endcase
   endfunction

   function automatic logic [127:0] rvec();
      return {rfield(), rfield(), rfield(), rfield()};
   endfunction

   // Drive one lookup and pin the 3-cycle latency and result with literals.
   task automatic lookup_check(input string name, input logic [127:0] bv, input logic [7:0] tag,
                               input logic exp_hit, input logic [4:0] exp_idx);
      bv_valid_in = 1'b1;
      bv_in       = bv;
      tag_in      = tag;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) bv_valid_in = 1'b0;
         if (k < 3) check({name, "_early_valid"}, 64'(match_valid), 64'd0);
      end
      check({name, "_valid"}, 64'(match_valid), 64'd1);
      check({name, "_hit"}, 64'(match_hit), 64'(exp_hit));
      check({name, "_idx"}, 64'(match_idx), 64'(exp_idx));
      check({name, "_tag"}, 64'(match_tag), 64'(tag));
   endtask

   initial begin
      rst_n       = 1'b0;
      bv_valid_in = 1'b1;
      bv_in       = {4{32'hFFFF_FFFF}};
      tag_in      = 8'h11;
      cnt_clr     = 1'b0;

      // Reset held with valid asserted: nothing may emerge.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cmp_en = 1'b1;
         check("reset_valid", 64'(match_valid), 64'd0);
      end
      rst_n       = 1'b1;
      bv_valid_in = 1'b0;
      @(negedge clk);
      check("reset_hit_cnt", 64'(hit_cnt), 64'd0);
      check("reset_miss_cnt", 64'(miss_cnt), 64'd0);

      lookup_check("single_hit", {32'h0000_0030, 32'hFFFF_FFFF, 32'h0000_0FF0, 32'h0000_00F0},
                   8'h5A, 1'b1, 5'd4);
      lookup_check("miss", {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001},
                   8'h33, 1'b0, 5'd0);
      @(negedge clk);
      check("miss_cnt_one", 64'(miss_cnt), 64'd1);
      check("hit_cnt_one", 64'(hit_cnt), 64'd1);
      lookup_check("top_bit", {{3{32'hFFFF_FFFF}}, 32'h8000_0000}, 8'h77, 1'b1, 5'd31);
      lookup_check("seg_edge", {{3{32'hFFFF_FFFF}}, 32'h0000_0100}, 8'h78, 1'b1, 5'd8);
      lookup_check("bit_zero", {{3{32'hFFFF_FFFF}}, 32'h8000_0001}, 8'h79, 1'b1, 5'd0);

      // Back-to-back stream, tags 0..19.
      for (int i = 0; i < 20; i++) begin
         bv_valid_in = 1'b1;
         bv_in       = rvec();
         tag_in      = 8'(i);
         @(negedge clk);
      end
      bv_valid_in = 1'b0;
      repeat (5) @(negedge clk);

      // Reset one cycle after the second of two lookups discards both.
      bv_valid_in = 1'b1; bv_in = {4{32'hFFFF_FFFF}}; tag_in = 8'hA1;
      @(negedge clk);
      tag_in = 8'hA2;
      @(negedge clk);
      bv_valid_in = 1'b0;
      rst_n       = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("flushed_valid", 64'(match_valid), 64'd0);
         @(negedge clk);
      end
      lookup_check("after_reset", {{3{32'hFFFF_FFFF}}, 32'h0000_0040}, 8'hB3, 1'b1, 5'd6);

      // Clear coinciding with a hit result wins.
      bv_valid_in = 1'b1; bv_in = {4{32'hFFFF_FFFF}}; tag_in = 8'hC1;
      @(negedge clk);
      bv_valid_in = 1'b0;
      repeat (2) @(negedge clk);
      check("clr_coincide_valid", 64'(match_valid), 64'd1);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      check("clr_hit_cnt", 64'(hit_cnt), 64'd0);

      // Saturation on the narrow counter instance.
      bv_valid_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tag_in = 8'(8'hD0 + i);
         @(negedge clk);
      end
      bv_valid_in = 1'b0;
      repeat (4) @(negedge clk);
      check("sat_hit_cnt_s", 64'(hc_s), 64'd7);
      check("wide_hit_cnt_10", 64'(hit_cnt), 64'd10);
      lookup_check("sat_extra", {4{32'hFFFF_FFFF}}, 8'hEE, 1'b1, 5'd0);
      @(negedge clk);
      check("sat_hold_s", 64'(hc_s), 64'd7);
      check("wide_hit_cnt_11", 64'(hit_cnt), 64'd11);

      // Random traffic with sparse clears and resets.
      for (int i = 0; i < 400; i++) begin
         bv_valid_in = ($urandom_range(0, 9) < 7);
         bv_in       = rvec();
         tag_in      = 8'($urandom);
         cnt_clr     = ($urandom_range(0, 49) == 0);
         rst_n       = ($urandom_range(0, 99) != 0);
         @(negedge clk);
      end
      rst_n       = 1'b1;
      cnt_clr     = 1'b0;
      bv_valid_in = 1'b0;
      repeat (6) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
